// File: rtl/game_control.sv
// game_control: round sequencer for the tile-memory game. Plays back the
// stored sequence, then drives the player stage through playerEN/checkEN
// and advances, wins or loses on its results.
module game_control #(
    parameter int SHOW_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 12500000,
    parameter int MAX_LEN     = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [17:0] seq,
    input  logic [3:0]  KEY,
    input  logic        player_input,
    input  logic        check,
    output logic        playerEN,
    output logic        checkEN,
    output logic [5:0]  seq_counter,
    output logic        show_en,
    output logic [1:0]  show_tile,
    output logic [3:0]  round_len,
    output logic        win,
    output logic        lose
);
    localparam int MAX_CYC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TW      = $clog2(MAX_CYC) + 1;
    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [3:0]    LEN_MAX   = 4'(MAX_LEN);

    typedef enum logic [3:0] {
        S_IDLE, S_SHOW_ON, S_SHOW_OFF, S_RELEASE, S_WAIT_INPUT,
        S_CHECK, S_EVAL, S_WIN, S_LOSE
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer;
    logic [5:0]    cnt_n;
    logic [3:0]    len_n;
    // Set for the dark gap that precedes a replay; that gap ends into tile 0
    // instead of advancing the tile index.
    logic          lead_gap, lead_n;
    logic          cnt_last;

    // tile i = {seq[2i], seq[2i+1]}, index decoded without out-of-range selects
    function automatic logic [1:0] tile_at(logic [17:0] s, logic [5:0] idx);
        logic [1:0] t;
        t = 2'b00;
        for (int i = 0; i < 9; i++)
            if (idx == 6'(i)) t = {s[2*i], s[2*i+1]};
        return t;
    endfunction

    assign cnt_last = (seq_counter == ({2'b00, round_len} - 6'd1));

    // Outputs decode purely from the state register
    assign show_en  = (state == S_SHOW_ON);
    assign playerEN = (state == S_WAIT_INPUT);
    assign checkEN  = (state == S_CHECK);
    assign win      = (state == S_WIN);
    assign lose     = (state == S_LOSE);

    // Next-state, tile index and round length
    always_comb begin
        state_n = state;
        cnt_n   = seq_counter;
        len_n   = round_len;
        lead_n  = lead_gap;
        case (state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    state_n = S_SHOW_ON;
                    cnt_n   = 6'd0;
                    len_n   = 4'd1;
                    lead_n  = 1'b0;
                end
            end
            S_SHOW_ON: begin
                if (timer == SHOW_LAST) state_n = S_SHOW_OFF;
            end
            S_SHOW_OFF: begin
                if (timer == GAP_LAST) begin
                    if (lead_gap) begin
                        state_n = S_SHOW_ON;
                        lead_n  = 1'b0;
                    end else if (cnt_last) begin
                        state_n = S_RELEASE;
                        cnt_n   = 6'd0;
                    end else begin
                        state_n = S_SHOW_ON;
                        cnt_n   = seq_counter + 6'd1;
                    end
                end
            end
            S_RELEASE: begin
                if (KEY == 4'hF) state_n = S_WAIT_INPUT;
            end
            S_WAIT_INPUT: begin
                if (player_input) state_n = S_CHECK;
            end
            S_CHECK: state_n = S_EVAL;
            S_EVAL: begin
                if (!check) begin
                    state_n = S_LOSE;
                end else if (!cnt_last) begin
                    state_n = S_RELEASE;
                    cnt_n   = seq_counter + 6'd1;
                end else if (round_len == LEN_MAX) begin
                    state_n = S_WIN;
                end else begin
                    state_n = S_SHOW_OFF;
                    len_n   = round_len + 4'd1;
                    cnt_n   = 6'd0;
                    lead_n  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, timer (cleared on every state entry) and registered tile output
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            timer       <= '0;
            seq_counter <= '0;
            round_len   <= '0;
            lead_gap    <= 1'b0;
            show_tile   <= 2'b00;
        end else begin
            state       <= state_n;
            seq_counter <= cnt_n;
            round_len   <= len_n;
            lead_gap    <= lead_n;
            if (state_n != state)
                timer <= '0;
            else if (state == S_SHOW_ON || state == S_SHOW_OFF)
                timer <= timer + TW'(1);
            show_tile <= (state_n == S_SHOW_ON) ? tile_at(seq, cnt_n) : 2'b00;
        end
    end
endmodule
